// File: rtl/display_pkg.sv
// Shared FSM state encoding, 7-segment digit table and default forward address
// for the display relay node.
package display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HOLD     = 2'd1,
    ST_SEND     = 2'd2,
    ST_WAIT_ACK = 2'd3
  } state_t;

  localparam logic [14:0] DEST_ADDR_DEFAULT = {3'b010, 12'b0};

  // gfedcba, active-high; element n lights decimal digit n
  localparam logic [9:0][6:0] SEG_LUT = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [6:0] SEG_ZERO = 7'h3F;

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] s;
    s = 7'h00;
    if (d <= 4'd9) s = SEG_LUT[d];
    return s;
  endfunction

endpackage

// File: rtl/display_bcd_seq.sv
// Sequential double-dabble binary-to-BCD with 7-segment encoding; one load cycle
// plus DATA_WIDTH shift cycles, seg_o updates atomically on the final shift.
module display_bcd_seq
  import display_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BCD_DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [DATA_WIDTH-1:0]   din_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [7*BCD_DIGITS-1:0] seg_o
);

  localparam int BW = 4 * BCD_DIGITS;
  localparam int SW = BW + DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  // BCD digits sit above the binary word; both shift left together
  logic [SW-1:0]           sr_q;
  logic [SW-1:0]           sr_d;
  logic [BW-1:0]           adj;
  logic [CW-1:0]           cnt_q;
  logic                    busy_q;
  logic                    done_q;
  logic [7*BCD_DIGITS-1:0] seg_q;
  logic [7*BCD_DIGITS-1:0] seg_d;

  always_comb begin
    adj = sr_q[SW-1 -: BW];
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    sr_d = {adj, sr_q[DATA_WIDTH-1:0]} << 1;
    seg_d = '0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      seg_d[7*i +: 7] = seg_encode(sr_d[DATA_WIDTH + 4*i +: 4]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      seg_q  <= {BCD_DIGITS{SEG_ZERO}};
    end else begin
      done_q <= 1'b0;
      if (busy_q) begin
        sr_q  <= sr_d;
        cnt_q <= cnt_q + CW'(1);
        if (cnt_q == CW'(DATA_WIDTH - 1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          seg_q  <= seg_d;
        end
      end else if (start_i) begin
        sr_q   <= {{BW{1'b0}}, din_i};
        cnt_q  <= '0;
        busy_q <= 1'b1;
      end
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign seg_o  = seg_q;

endmodule

// File: rtl/display_relay_ctrl.sv
// Queues slave-written words, shows the newest on 7-segment digits and forwards
// each (plus INCR) to DEST_ADDR after a hold delay, with ack timeout and bounded retry.
module display_relay_ctrl
  import display_pkg::*;
#(
  parameter int                     DATA_WIDTH  = 8,
  parameter int                     ADDRS_WIDTH = 15,
  parameter int                     FIFO_DEPTH  = 4,
  parameter int                     HOLD_LEN    = 6,
  parameter int                     ACK_TO_LEN  = 8,
  parameter int                     MAX_RETRY   = 3,
  parameter int                     INCR        = 1,
  parameter logic [ADDRS_WIDTH-1:0] DEST_ADDR   = ADDRS_WIDTH'(DEST_ADDR_DEFAULT),
  parameter int                     BCD_DIGITS  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_wr_en,
  input  logic [DATA_WIDTH-1:0]   s_din,
  output logic                    s_dv,
  output logic                    m_hold,
  output logic                    m_execute,
  output logic [ADDRS_WIDTH-1:0]  m_address,
  output logic [DATA_WIDTH-1:0]   m_din,
  input  logic                    m_dvalid,
  input  logic                    m_master_bsy,
  output logic [7*BCD_DIGITS-1:0] seg,
  output logic                    fifo_full,
  output logic                    overflow,
  output logic                    err,
  output logic [7:0]              fail_cnt
);

  localparam int          AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          RW       = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         rd_ptr_q;
  logic [AW:0]           cnt_q;
  logic                  overflow_q;
  logic                  full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;

  state_t                state_q;
  logic [HOLD_LEN-1:0]   hold_tmr_q;
  logic [ACK_TO_LEN-1:0] ack_tmr_q;
  logic [RW-1:0]         retry_q;
  logic [7:0]            fail_cnt_q;
  logic                  m_hold_q;
  logic                  m_execute_q;
  logic                  s_dv_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] m_din_q;
  logic                  ack_timeout;
  logic                  retry_exhausted;

  logic [DATA_WIDTH-1:0] latest_q;
  logic                  pend_q;
  logic                  pend_d;
  logic                  conv_start;
  logic [DATA_WIDTH-1:0] conv_din;
  logic                  conv_busy;
  logic                  conv_done;

  assign ack_timeout     = &ack_tmr_q;
  assign retry_exhausted = (retry_q == RW'(MAX_RETRY));
  assign pop        = (state_q == ST_WAIT_ACK) && (m_dvalid || (ack_timeout && retry_exhausted));
  assign full       = (cnt_q == FULL_CNT);
  assign fifo_empty = (cnt_q == '0);
  // A pop in the same cycle frees the slot, so a write into a full queue still lands
  assign push       = s_wr_en && (!full || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      cnt_q <= cnt_q + (AW + 1)'(1);
      else if (pop && !push) cnt_q <= cnt_q - (AW + 1)'(1);
      if (s_wr_en && !push) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_din;
  end

  // Conversions are never aborted; a newer word waits in latest_q until the current one ends
  assign conv_start = (push && !conv_busy) || (pend_q && conv_done);
  assign conv_din   = push ? s_din : latest_q;

  always_comb begin
    pend_d = pend_q;
    if (conv_start) pend_d = 1'b0;
    else if (push)  pend_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      latest_q <= '0;
      pend_q   <= 1'b0;
    end else begin
      if (push) latest_q <= s_din;
      pend_q <= pend_d;
    end
  end

  display_bcd_seq #(
    .DATA_WIDTH (DATA_WIDTH),
    .BCD_DIGITS (BCD_DIGITS)
  ) u_bcd (
    .clk     (clk),
    .rst     (rst),
    .start_i (conv_start),
    .din_i   (conv_din),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .seg_o   (seg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hold_tmr_q  <= '0;
      ack_tmr_q   <= '0;
      retry_q     <= '0;
      fail_cnt_q  <= '0;
      m_hold_q    <= 1'b0;
      m_execute_q <= 1'b0;
      s_dv_q      <= 1'b0;
      err_q       <= 1'b0;
      m_din_q     <= '0;
    end else begin
      m_execute_q <= 1'b0;
      s_dv_q      <= 1'b0;
      err_q       <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          m_hold_q <= 1'b0;
          if (!fifo_empty) begin
            hold_tmr_q <= '0;
            state_q    <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          hold_tmr_q <= hold_tmr_q + HOLD_LEN'(1);
          if (&hold_tmr_q) begin
            m_hold_q <= 1'b1;
            m_din_q  <= mem_q[rd_ptr_q] + DATA_WIDTH'(INCR);
            state_q  <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (!m_master_bsy) begin
            m_execute_q <= 1'b1;
            ack_tmr_q   <= '0;
            state_q     <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          ack_tmr_q <= ack_tmr_q + ACK_TO_LEN'(1);
          if (m_dvalid) begin
            s_dv_q   <= 1'b1;
            retry_q  <= '0;
            m_hold_q <= 1'b0;
            state_q  <= ST_IDLE;
          end else if (ack_timeout) begin
            if (!retry_exhausted) begin
              retry_q <= retry_q + RW'(1);
              state_q <= ST_SEND;
            end else begin
              err_q    <= 1'b1;
              if (fail_cnt_q != 8'hFF) fail_cnt_q <= fail_cnt_q + 8'd1;
              retry_q  <= '0;
              m_hold_q <= 1'b0;
              state_q  <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign s_dv      = s_dv_q;
  assign m_hold    = m_hold_q;
  assign m_execute = m_execute_q;
  assign m_address = DEST_ADDR;
  assign m_din     = m_din_q;
  assign fifo_full = full;
  assign overflow  = overflow_q;
  assign err       = err_q;
  assign fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_display_relay_ctrl.sv
// Bench for display_relay_ctrl: directed scenarios plus a randomized run scored
// against a queue-based model of the receive FIFO, display and forward rules.
module tb_display_relay_ctrl;

  localparam int DW       = 8;
  localparam int DEPTH    = 4;
  localparam int HOLD_CYC = 64;
  localparam int ACK_CYC  = 256;
  localparam int ATTEMPTS = 4;
  localparam int INCR     = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_wr_en = 1'b0;
  logic [7:0]  s_din = '0;
  logic        s_dv;
  logic        m_hold;
  logic        m_execute;
  logic [14:0] m_address;
  logic [7:0]  m_din;
  logic        m_dvalid = 1'b0;
  logic        m_master_bsy = 1'b0;
  logic [20:0] seg;
  logic        fifo_full;
  logic        overflow;
  logic        err;
  logic [7:0]  fail_cnt;

  int checks   = 0;
  int failures = 0;

  int mq[$];
  int m_last = 0;
  bit m_ovf  = 1'b0;
  int m_fail = 0;

  always #5 clk = ~clk;

  display_relay_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .s_wr_en      (s_wr_en),
    .s_din        (s_din),
    .s_dv         (s_dv),
    .m_hold       (m_hold),
    .m_execute    (m_execute),
    .m_address    (m_address),
    .m_din        (m_din),
    .m_dvalid     (m_dvalid),
    .m_master_bsy (m_master_bsy),
    .seg          (seg),
    .fifo_full    (fifo_full),
    .overflow     (overflow),
    .err          (err),
    .fail_cnt     (fail_cnt)
  );

  function automatic logic [20:0] seg_of(input int v);
    logic [6:0] tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    logic [20:0] r;
    r[6:0]   = tbl[v % 10];
    r[13:7]  = tbl[(v / 10) % 10];
    r[20:14] = tbl[(v / 100) % 10];
    return r;
  endfunction

  function automatic logic [7:0] fwd(input int v);
    return 8'((v + INCR) % 256);
  endfunction

  task automatic clear_model();
    mq.delete();
    m_last = 0;
    m_ovf  = 1'b0;
    m_fail = 0;
  endtask

  // One clock: drive, advance, sample 1 ns after the edge and update the model
  task automatic step(input bit wr, input int d);
    bit popped;
    s_wr_en = wr;
    s_din   = d[7:0];
    @(posedge clk);
    #1;
    s_wr_en = 1'b0;
    popped = (s_dv === 1'b1) || (err === 1'b1);
    if (popped && mq.size() > 0) void'(mq.pop_front());
    if (err === 1'b1 && m_fail < 255) m_fail++;
    if (wr) begin
      if (mq.size() < DEPTH) begin
        mq.push_back(d % 256);
        m_last = d % 256;
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic do_ack();
    m_dvalid = 1'b1;
    step(1'b0, 0);
    m_dvalid = 1'b0;
  endtask

  // sel: 0 = m_hold high, 1 = m_execute pulse, 2 = err pulse; n = -1 on timeout
  task automatic wait_for(input int sel, input int bound, output int n);
    n = -1;
    for (int i = 0; i < bound; i++) begin
      step(1'b0, 0);
      if ((sel == 0 && m_hold === 1'b1) || (sel == 1 && m_execute === 1'b1) ||
          (sel == 2 && err === 1'b1)) begin
        n = i + 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m_dvalid = 1'b0;
    m_master_bsy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({s_dv, m_hold, m_execute, fifo_full, overflow, err} !== 6'b0)
      begin failures++; $display("FAIL reset_flags got=%b want=000000", {s_dv, m_hold, m_execute, fifo_full, overflow, err}); end
    checks++;
    if (fail_cnt !== 8'd0 || m_din !== 8'd0)
      begin failures++; $display("FAIL reset_regs fail_cnt=%0d m_din=%0d want 0/0", fail_cnt, m_din); end
    checks++;
    if (seg !== seg_of(0)) begin failures++; $display("FAIL reset_seg got=%h want=%h", seg, seg_of(0)); end
    checks++;
    if (m_address !== 15'h2000) begin failures++; $display("FAIL reset_addr got=%h want=2000", m_address); end
    rst = 1'b0;
    clear_model();
    repeat (5) step(1'b0, 0);
    checks++;
    if (m_hold !== 1'b0) begin failures++; $display("FAIL idle_empty_hold got=%b want=0", m_hold); end
  endtask

  task automatic test_forward_basic();
    int n;
    int nexec;
    step(1'b1, 41);
    repeat (DW) step(1'b0, 0);
    checks++;
    if (seg !== seg_of(41)) begin failures++; $display("FAIL basic_seg got=%h want=%h", seg, seg_of(41)); end
    wait_for(0, 200, n);
    checks++;
    if (n < 0 || DW + n < HOLD_CYC || DW + n > HOLD_CYC + 2)
      begin failures++; $display("FAIL basic_hold_delay got=%0d want=%0d..%0d", DW + n, HOLD_CYC, HOLD_CYC + 2); end
    wait_for(1, 10, n);
    checks++;
    if (n < 0) begin failures++; $display("FAIL basic_exec_timeout got=none want=pulse"); end
    checks++;
    if (m_din !== fwd(41) || m_address !== 15'h2000)
      begin failures++; $display("FAIL basic_fwd m_din=%0d addr=%h want %0d/2000", m_din, m_address, fwd(41)); end
    nexec = 0;
    step(1'b0, 0);
    if (m_execute === 1'b1) nexec++;
    checks++;
    if (nexec != 0) begin failures++; $display("FAIL basic_exec_width got=%0d extra want=0", nexec); end
    do_ack();
    checks++;
    if (s_dv !== 1'b1 || m_hold !== 1'b0)
      begin failures++; $display("FAIL basic_ack s_dv=%b m_hold=%b want 1/0", s_dv, m_hold); end
    step(1'b0, 0);
    checks++;
    if (s_dv !== 1'b0) begin failures++; $display("FAIL basic_sdv_width got=%b want=0", s_dv); end
  endtask

  task automatic test_wrap();
    int n;
    step(1'b1, 255);
    repeat (DW) step(1'b0, 0);
    checks++;
    if (seg !== seg_of(255)) begin failures++; $display("FAIL wrap_seg got=%h want=%h", seg, seg_of(255)); end
    wait_for(1, 200, n);
    checks++;
    if (n < 0 || m_din !== 8'd0) begin failures++; $display("FAIL wrap_fwd n=%0d m_din=%0d want=0", n, m_din); end
    do_ack();
    checks++;
    if (s_dv !== 1'b1) begin failures++; $display("FAIL wrap_ack got=%b want=1", s_dv); end
  endtask

  task automatic test_overflow();
    int w[4];
    int w5;
    int n;
    for (int i = 0; i < 4; i++) w[i] = $urandom_range(0, 255);
    w5 = (w[3] + 1 + $urandom_range(0, 200)) % 256;
    for (int i = 0; i < 4; i++) step(1'b1, w[i]);
    checks++;
    if (fifo_full !== 1'b1 || overflow !== 1'b0)
      begin failures++; $display("FAIL ovf_full full=%b ovf=%b want 1/0", fifo_full, overflow); end
    step(1'b1, w5);
    checks++;
    if (overflow !== 1'b1 || fifo_full !== 1'b1)
      begin failures++; $display("FAIL ovf_drop ovf=%b full=%b want 1/1", overflow, fifo_full); end
    repeat (30) step(1'b0, 0);
    checks++;
    if (seg !== seg_of(m_last)) begin failures++; $display("FAIL ovf_seg got=%h want=%h", seg, seg_of(m_last)); end
    for (int k = 0; k < 4; k++) begin
      wait_for(1, 400, n);
      checks++;
      if (n < 0 || mq.size() == 0 || m_din !== fwd(mq[0]))
        begin failures++; $display("FAIL ovf_drain%0d n=%0d m_din=%0d want=%0d", k, n, m_din, (mq.size() > 0) ? fwd(mq[0]) : -1); end
      step(1'b0, 0);
      do_ack();
    end
    checks++;
    if (fifo_full !== 1'b0 || overflow !== 1'b1)
      begin failures++; $display("FAIL ovf_after full=%b ovf=%b want 0/1", fifo_full, overflow); end
  endtask

  task automatic test_retry_drop();
    int a;
    int b;
    int nexec = 0;
    int last = -1;
    int t = 0;
    int bad_gap = 0;
    int first_din = -1;
    bit got_err = 1'b0;
    int n;
    a = $urandom_range(0, 255);
    b = $urandom_range(0, 255);
    step(1'b1, a);
    step(1'b1, b);
    for (int i = 0; i < 3000 && !got_err; i++) begin
      step(1'b0, 0);
      t++;
      if (m_execute === 1'b1) begin
        if (nexec == 0) first_din = int'(m_din);
        if (last >= 0 && (t - last < ACK_CYC || t - last > ACK_CYC + 1)) bad_gap++;
        last = t;
        nexec++;
      end
      if (err === 1'b1) got_err = 1'b1;
    end
    checks++;
    if (!got_err || nexec != ATTEMPTS)
      begin failures++; $display("FAIL retry_count err=%b execs=%0d want 1/%0d", got_err, nexec, ATTEMPTS); end
    checks++;
    if (bad_gap != 0 || first_din != int'(fwd(a)))
      begin failures++; $display("FAIL retry_spacing bad_gaps=%0d din=%0d want 0/%0d", bad_gap, first_din, fwd(a)); end
    checks++;
    if (fail_cnt !== 8'(m_fail) || m_hold !== 1'b0)
      begin failures++; $display("FAIL retry_drop fail_cnt=%0d m_hold=%b want %0d/0", fail_cnt, m_hold, m_fail); end
    step(1'b0, 0);
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL retry_err_width got=%b want=0", err); end
    wait_for(1, 200, n);
    checks++;
    if (n < 0 || m_din !== fwd(b)) begin failures++; $display("FAIL retry_next n=%0d m_din=%0d want=%0d", n, m_din, fwd(b)); end
    do_ack();
  endtask

  task automatic test_busy_stall();
    int w;
    int n;
    int nexec = 0;
    w = $urandom_range(0, 255);
    step(1'b1, w);
    m_master_bsy = 1'b1;
    wait_for(0, 200, n);
    repeat (20) begin
      step(1'b0, 0);
      if (m_execute === 1'b1) nexec++;
    end
    checks++;
    if (n < 0 || nexec != 0 || m_hold !== 1'b1)
      begin failures++; $display("FAIL busy_stall n=%0d execs=%0d m_hold=%b want 0 execs, hold 1", n, nexec, m_hold); end
    m_master_bsy = 1'b0;
    nexec = 0;
    repeat (5) begin
      step(1'b0, 0);
      if (m_execute === 1'b1) nexec++;
    end
    checks++;
    if (nexec != 1 || m_din !== fwd(w))
      begin failures++; $display("FAIL busy_release execs=%0d m_din=%0d want 1/%0d", nexec, m_din, fwd(w)); end
    do_ack();
    checks++;
    if (s_dv !== 1'b1) begin failures++; $display("FAIL busy_ack got=%b want=1", s_dv); end
  endtask

  task automatic test_reset_mid();
    int n;
    int seen = 0;
    step(1'b1, $urandom_range(0, 255));
    wait_for(1, 200, n);
    checks++;
    if (n < 0) begin failures++; $display("FAIL rstmid_exec_timeout got=none want=pulse"); end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({m_hold, m_execute, overflow, s_dv, err, fifo_full} !== 6'b0)
      begin failures++; $display("FAIL rstmid_flags got=%b want=000000", {m_hold, m_execute, overflow, s_dv, err, fifo_full}); end
    checks++;
    if (fail_cnt !== 8'd0 || seg !== seg_of(0))
      begin failures++; $display("FAIL rstmid_regs fail_cnt=%0d seg=%h want 0/%h", fail_cnt, seg, seg_of(0)); end
    @(posedge clk);
    #1 rst = 1'b0;
    clear_model();
    do_ack();
    repeat (100) begin
      step(1'b0, 0);
      if (m_hold === 1'b1 || m_execute === 1'b1 || s_dv === 1'b1) seen++;
    end
    checks++;
    if (s_dv !== 1'b0 || seen != 0) begin failures++; $display("FAIL rstmid_late_ack activity=%0d want=0", seen); end
  endtask

  task automatic test_random();
    int pending_ack = -1;
    int unexpected = 0;
    bit ack_now;
    bit wr;
    for (int c = 0; c < 5000; c++) begin
      wr = (c < 3000) && ($urandom_range(0, 9) == 0);
      m_master_bsy = ($urandom_range(0, 3) == 0);
      ack_now = 1'b0;
      if (pending_ack == 0) begin
        m_dvalid = 1'b1;
        ack_now = 1'b1;
        pending_ack = -1;
      end else if (pending_ack > 0) begin
        pending_ack--;
      end
      step(wr, $urandom_range(0, 255));
      m_dvalid = 1'b0;
      if (s_dv === 1'b1 && !ack_now) unexpected++;
      if (m_execute === 1'b1) begin
        checks++;
        if (mq.size() == 0 || m_din !== fwd(mq[0]))
          begin failures++; $display("FAIL rand_fwd cyc=%0d m_din=%0d want=%0d", c, m_din, (mq.size() > 0) ? fwd(mq[0]) : -1); end
        if (c < 3000 && $urandom_range(0, 4) == 0) pending_ack = -1;
        else pending_ack = $urandom_range(0, 40);
      end
    end
    m_master_bsy = 1'b0;
    checks++;
    if (mq.size() != 0 || unexpected != 0 || m_hold !== 1'b0)
      begin failures++; $display("FAIL rand_drain left=%0d stray_sdv=%0d m_hold=%b want 0/0/0", mq.size(), unexpected, m_hold); end
    checks++;
    if (seg !== seg_of(m_last)) begin failures++; $display("FAIL rand_seg got=%h want=%h", seg, seg_of(m_last)); end
    checks++;
    if (overflow !== m_ovf || fail_cnt !== 8'(m_fail) || fifo_full !== 1'b0)
      begin failures++; $display("FAIL rand_flags ovf=%b fail_cnt=%0d full=%b want %b/%0d/0", overflow, fail_cnt, fifo_full, m_ovf, m_fail); end
  endtask

  initial begin
    test_reset();
    test_forward_basic();
    test_wrap();
    test_overflow();
    test_retry_drop();
    test_busy_stall();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
